mem_bridge: RTL

MEM_BRIDGE -- requirements
Module: mem_bridge

---
 rtl/mem_bridge_pkg.sv | 43 ++++
 rtl/mem_bridge_ram.sv | 29 ++
 rtl/mem_bridge.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared definitions for the mem_bridge slice.
//   MAS access-size encodings, FSM state type, wait-counter width and the
//   lane helpers used for read replication and write byte enables.
package mem_bridge_pkg;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;
  localparam logic [1:0] MAS_RSVD = 2'b11;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Byte-lane write enables; lane 0 is byte address ...00 (little endian).
  // Reserved size falls through to word.
  function automatic logic [3:0] lane_en(input logic [1:0] mas, input logic [1:0] lo);
    case (mas)
      MAS_BYTE: lane_en = 4'b0001 << lo;
      MAS_HALF: lane_en = lo[1] ? 4'b1100 : 4'b0011;
      default:  lane_en = 4'b1111;
    endcase
  endfunction

  // Read formatting: byte/halfword replicated across the bus, word unrotated.
  function automatic logic [31:0] rd_lanes(input logic [31:0] w, input logic [1:0] mas,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (mas)
      MAS_BYTE: rd_lanes = {4{b}};
      MAS_HALF: rd_lanes = {2{h}};
      default:  rd_lanes = w;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_ram.sv
// mem_bridge_ram: single-port synchronous RAM, 32-bit words, 4 byte-lane
// write enables, registered read output. Contents are never reset.
//   clk   - clock
//   we    - per-lane write enables (lane i = wdata[8i+7:8i])
//   re    - read enable; rdata holds when low
//   addr  - word index
//   wdata - write data
//   rdata - registered read data
module mem_bridge_ram #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic [3:0]           we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [0:(1 << ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: pipelined CPU bus to single-port RAM bridge with N/S wait states.
//   MCLK, RESET      - clock, asynchronous active-high reset
//   A, nMREQ, SEQ,   - address-phase request (latched when nMREQ=0, nWAIT=1)
//   nRW, MAS
//   DOUT             - CPU write data (data phase)
//   DIN              - read data (valid in DATA, held otherwise)
//   nWAIT            - low while stretching the data phase
//   ABORT            - access aborted (only with MEM_BRIDGE_ABORT_EN defined:
//                      out-of-range address or reserved size)
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned NWAIT_N   = 2,
  parameter int unsigned NWAIT_S   = 0
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic        nMREQ,
  input  logic        SEQ,
  input  logic        nRW,
  input  logic [1:0]  MAS,
  input  logic [31:0] DOUT,
  output logic [31:0] DIN,
  output logic        nWAIT,
  output logic        ABORT
);

  localparam logic [CNT_W-1:0] WAIT_N = CNT_W'(NWAIT_N);
  localparam logic [CNT_W-1:0] WAIT_S = CNT_W'(NWAIT_S);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx, wc;
  logic [ADDR_BITS-1:0] lat_idx, a_idx;
  logic [1:0]           lat_lo, lat_mas;
  logic                 lat_rw, lat_bad;
  logic                 acc, acc_rd, wr_end, drain, fwd, show;
  logic [31:0]          din_q, din_now, rd_word, ram_q, ram_wdata;
  logic [3:0]           ram_we;
  logic                 ram_re;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 buf_v;
  logic [ADDR_BITS-1:0] buf_idx;
  logic [3:0]           buf_be;
  logic [31:0]          buf_data;

  assign a_idx  = A[ADDR_BITS+1:2];
  assign acc    = !nMREQ && (state != ST_WAIT);
  assign acc_rd = acc && !nRW;
  assign wc     = (SEQ && state == ST_DATA) ? WAIT_S : WAIT_N;
  assign wr_end = (state == ST_DATA) && lat_rw && !lat_bad;

`ifdef MEM_BRIDGE_ABORT_EN
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)    lat_bad <= 1'b0;
    else if (acc) lat_bad <= (|A[31:ADDR_BITS+2]) || (MAS == MAS_RSVD);
  end
`else
  logic unused_hi;
  assign unused_hi = ^A[31:ADDR_BITS+2];
  assign lat_bad   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    case (state)
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) state_nx = ST_DATA;
        else                  cnt_nx   = cnt - CNT_W'(1);
      end
      default: begin
        if (acc) begin
          if (wc != '0) begin
            state_nx = ST_WAIT;
            cnt_nx   = wc;
          end else begin
            state_nx = ST_DATA;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
    endcase
    nWAIT = (state != ST_WAIT);
    ABORT = (state == ST_DATA) && lat_bad;
  end

  // The single RAM port is needed both to launch a read at the accept edge
  // and to commit a write at the end of DATA. When they coincide the write is
  // parked in buf_* (forwarded into reads) and committed on the next edge
  // where the port is free. Draining is held off in WAIT so that a read
  // already issued keeps seeing the parked bytes through forwarding.
  assign drain = buf_v && !acc_rd && !wr_end && (state != ST_WAIT);
  assign fwd   = buf_v && (buf_idx == lat_idx);

  always_comb begin
    ram_re    = 1'b0;
    ram_we    = '0;
    ram_addr  = lat_idx;
    ram_wdata = DOUT;
    if (acc_rd) begin
      ram_re   = 1'b1;
      ram_addr = a_idx;
    end else if (wr_end) begin
      ram_we = lane_en(lat_mas, lat_lo);
    end else if (drain) begin
      ram_we    = buf_be;
      ram_addr  = buf_idx;
      ram_wdata = buf_data;
    end
  end

  always_comb begin
    rd_word = ram_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (fwd && buf_be[i]) rd_word[8*i +: 8] = buf_data[8*i +: 8];
    end
    din_now = lat_bad ? '0 : rd_lanes(rd_word, lat_mas, lat_lo);
    show    = (state == ST_DATA) && (!lat_rw || lat_bad);
    DIN     = show ? din_now : din_q;
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_idx  <= '0;
      lat_lo   <= '0;
      lat_mas  <= '0;
      lat_rw   <= 1'b0;
      din_q    <= '0;
      buf_v    <= 1'b0;
      buf_idx  <= '0;
      buf_be   <= '0;
      buf_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (acc) begin
        lat_idx <= a_idx;
        lat_lo  <= A[1:0];
        lat_mas <= MAS;
        lat_rw  <= nRW;
      end
      if (show) din_q <= din_now;
      if (wr_end && acc_rd) begin
        buf_v    <= 1'b1;
        buf_idx  <= lat_idx;
        buf_be   <= lane_en(lat_mas, lat_lo);
        buf_data <= DOUT;
      end else if (drain) begin
        buf_v <= 1'b0;
      end
    end
  end

  mem_bridge_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (MCLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

endmodule
